time_entry_ctrl: RTL and testbench
==================================

TIME_ENTRY_CTRL -- requirements
Module: time_entry_ctrl

Interface
REQ-001 The module SHALL have parameter KEY_BACK, default 4'd10, the key code that steps entry back one digit.
REQ-002 The module SHALL have parameter KEY_CLEAR, default 4'd11, the key code that restarts entry.
REQ-003 mclk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
REQ-006 key_code  input  4  0-9 are digits; KEY_BACK and KEY_CLEAR are commands; other codes are ignored.
REQ-007 min_p  input  1  one-cycle minute tick, synchronous to mclk.
REQ-008 nowH  output  5  current hour in binary, 0-23.
REQ-009 nowM  output  6  current minute in binary, 0-59.
REQ-010 timerH  output  5  timer hour in binary, 0-23.
REQ-011 timerM  output  6  timer minute in binary, 0-59.
REQ-012 master_status  output  4  entry position 0-7, or 8 = RUN.
REQ-013 alarm  output  1  one-cycle pulse; now has reached the timer value.
REQ-014 entry_err  output  1  one-cycle pulse; a digit was rejected.

Function
REQ-015 Eight BCD digits SHALL be held internally, at positions 0-7: nowH tens, nowH ones, nowM tens, nowM ones, timerH tens, timerH ones, timerM tens, timerM ones.
REQ-016 Each of nowH, nowM, timerH and timerM SHALL be a register equal to tens*10+ones of its digits, updated on the same edge as those digits; latency is one edge from key_valid.
REQ-017 master_status SHALL be a state counter: values 0-7 are ENTRY, where the value is the digit position awaiting input; 8 is RUN.
REQ-018 In ENTRY, an accepted digit SHALL be stored at position master_status, and master_status SHALL then increment; an accept at 7 SHALL enter RUN (8).
REQ-019 Digit acceptance limits SHALL be:
  - hour tens: 0-2
  - hour ones: 0-9, or 0-3 when the hour tens digit is 2
  - minute tens: 0-5
  - minute ones: 0-9
REQ-020 A rejected digit SHALL leave all state unchanged and SHALL assert entry_err for exactly one cycle.
REQ-021 While master_status<8, every digit at a position >= master_status SHALL be zero.
REQ-022 KEY_BACK at master_status k>0 SHALL set master_status to k-1 and zero digit k-1; KEY_BACK at 0 SHALL do nothing.
REQ-023 KEY_CLEAR in any state SHALL zero all digits and set master_status to 0.
REQ-024 In RUN, digit keys SHALL be ignored and SHALL NOT assert entry_err.
REQ-025 min_p SHALL be ignored while master_status<8.
REQ-026 In RUN, min_p SHALL increment nowM; 59 SHALL wrap to 0 with a nowH increment; 23:59 SHALL wrap to 00:00.
REQ-027 When key_valid with KEY_BACK or KEY_CLEAR coincides with min_p in RUN, the key SHALL take effect and that min_p SHALL be dropped.
REQ-028 When key_valid with a digit or an ignored code coincides with min_p in RUN, min_p SHALL apply.
REQ-029 alarm SHALL pulse for one cycle, registered on the edge after a min_p increment makes {nowH,nowM} equal {timerH,timerM}.
REQ-030 Completing entry into RUN with now equal to timer SHALL NOT raise alarm.
REQ-031 key_valid with codes 12-15 (when not a command) SHALL be ignored in all states.

Reset
REQ-032 Asserting rst SHALL immediately clear all digits, all four time outputs, master_status, alarm and entry_err to 0, without waiting for mclk.
REQ-033 rst asserted mid-entry or mid-RUN SHALL discard all progress; after release, entry SHALL restart at position 0.
REQ-034 key_valid and min_p SHALL have no effect while rst is high.

Verification
REQ-035 Entry: keys 1,2,3,4,0,7,3,0 -> master_status steps 1..8; outputs read nowH=12, nowM=34, timerH=7, timerM=30.
REQ-036 Validation: key 2 then 5 at positions 0/1 -> 5 rejected, entry_err one pulse, master_status stays 1; key 3 -> nowH=23.
REQ-037 Wrap: RUN at 23:59, one min_p -> nowH=0, nowM=0.
REQ-038 Alarm: now 06:59, timer 07:00, min_p -> nowH=7, nowM=0, alarm high exactly one cycle, on the following edge.
REQ-039 Back/clear: in RUN, KEY_BACK with min_p coincident -> master_status=7, timerM ones=0, nowM unchanged; KEY_CLEAR -> all outputs 0, master_status=0.
REQ-040 Reset mid-entry at master_status=5 -> all outputs 0 asynchronously; digit key after release stores at position 0.

Source files
------------

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: keypad entry of current/timer time as BCD digits, then minute-tick clock with alarm
module time_entry_ctrl #(
  parameter logic [3:0] KEY_BACK  = 4'd10,
  parameter logic [3:0] KEY_CLEAR = 4'd11
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       min_p,
  output logic [4:0] nowH,
  output logic [5:0] nowM,
  output logic [4:0] timerH,
  output logic [5:0] timerM,
  output logic [3:0] master_status,
  output logic       alarm,
  output logic       entry_err
);
  logic [3:0] d [8];
  logic [3:0] nd [8];
  logic [3:0] nms, lim;
  logic [2:0] p;
  logic       run, is_back, is_clr, is_dig, err, tick, tick_q;

  function automatic logic [6:0] bcd2bin(input logic [3:0] t, input logic [3:0] o);
    return 7'(t) * 7'd10 + 7'(o);
  endfunction

  assign run     = master_status[3];
  assign p       = master_status[2:0];
  assign is_clr  = key_valid && key_code == KEY_CLEAR;
  assign is_back = key_valid && !is_clr && key_code == KEY_BACK;
  assign is_dig  = key_valid && !is_clr && !is_back && key_code <= 4'd9;
  assign lim     = p[0] ? ((!p[1] && d[{p[2], 2'b00}] == 4'd2) ? 4'd3 : 4'd9) : (p[1] ? 4'd5 : 4'd2);

  // next digits/position: commands first, then digit entry, then minute tick in RUN
  always_comb begin
    nd   = d;
    nms  = master_status;
    err  = 1'b0;
    tick = 1'b0;
    if (is_clr) begin
      for (int i = 0; i < 8; i++) nd[i] = 4'd0;
      nms = 4'd0;
    end else if (is_back) begin
      if (master_status != 4'd0) begin
        nms = master_status - 4'd1;
        nd[3'(master_status - 4'd1)] = 4'd0;
      end
    end else if (!run) begin
      if (is_dig && key_code <= lim) begin
        nd[p] = key_code;
        nms   = master_status + 4'd1;
      end else if (is_dig) err = 1'b1;
    end else if (min_p) begin
      tick = 1'b1;
      if (d[3] != 4'd9) nd[3] = d[3] + 4'd1;
      else begin
        nd[3] = 4'd0;
        if (d[2] != 4'd5) nd[2] = d[2] + 4'd1;
        else begin
          nd[2] = 4'd0;
          if (d[0] == 4'd2 && d[1] == 4'd3) begin
            nd[0] = 4'd0;
            nd[1] = 4'd0;
          end else if (d[1] == 4'd9) begin
            nd[1] = 4'd0;
            nd[0] = d[0] + 4'd1;
          end else nd[1] = d[1] + 4'd1;
        end
      end
    end
  end

  // state, binary time registers and one-cycle pulses; alarm lands one edge after the tick
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) d[i] <= 4'd0;
      master_status <= 4'd0;
      nowH          <= 5'd0;
      nowM          <= 6'd0;
      timerH        <= 5'd0;
      timerM        <= 6'd0;
      alarm         <= 1'b0;
      entry_err     <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      d             <= nd;
      master_status <= nms;
      nowH          <= 5'(bcd2bin(nd[0], nd[1]));
      nowM          <= 6'(bcd2bin(nd[2], nd[3]));
      timerH        <= 5'(bcd2bin(nd[4], nd[5]));
      timerM        <= 6'(bcd2bin(nd[6], nd[7]));
      entry_err     <= err;
      tick_q        <= tick;
      alarm         <= tick_q && run && {nowH, nowM} == {timerH, timerM};
    end
  end
endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb_time_entry_ctrl: directed vectors with a queued scoreboard checked by an independent monitor
module tb_time_entry_ctrl;
  localparam logic [3:0] BK = 4'd10, CL = 4'd11;
  typedef struct packed {
    logic [3:0] ms;
    logic [4:0] nh;
    logic [5:0] nm;
    logic [4:0] th;
    logic [5:0] tm;
    logic       al;
    logic       er;
  } exp_t;

  logic       mclk = 1'b0, rst = 1'b1, key_valid = 1'b0, min_p = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [4:0] nowH, timerH;
  logic [5:0] nowM, timerM;
  logic [3:0] master_status;
  logic       alarm, entry_err;
  int         total = 0, bad = 0;
  exp_t       q [$];
  string      nq [$];

  time_entry_ctrl dut (
    .mclk(mclk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .min_p(min_p),
    .nowH(nowH), .nowM(nowM), .timerH(timerH), .timerM(timerM),
    .master_status(master_status), .alarm(alarm), .entry_err(entry_err)
  );

  always #5 mclk = ~mclk;

  function automatic exp_t e(input int ms, nh, nm, th, tm, al, er);
    return '{4'(ms), 5'(nh), 6'(nm), 5'(th), 6'(tm), 1'(al), 1'(er)};
  endfunction

  function automatic exp_t snap();
    return {master_status, nowH, nowM, timerH, timerM, alarm, entry_err};
  endfunction

  function automatic void chk(input string n, input exp_t got, input exp_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got ms=%0d now=%0d:%0d tmr=%0d:%0d al=%b er=%b, want ms=%0d now=%0d:%0d tmr=%0d:%0d al=%b er=%b",
               n, got.ms, got.nh, got.nm, got.th, got.tm, got.al, got.er,
               want.ms, want.nh, want.nm, want.th, want.tm, want.al, want.er);
    end
  endfunction

  task automatic st(input logic kv, input logic [3:0] kc, input logic mp, input string n, input exp_t x);
    @(negedge mclk);
    key_valid = kv;
    key_code  = kc;
    min_p     = mp;
    q.push_back(x);
    nq.push_back(n);
  endtask

  task automatic key(input logic [3:0] kc, input string n, input exp_t x);
    st(1'b1, kc, 1'b0, n, x);
  endtask

  task automatic idle(input string n, input exp_t x);
    st(1'b0, 4'd0, 1'b0, n, x);
  endtask

  initial begin
    forever begin
      @(posedge mclk);
      #2;
      if (q.size() > 0) chk(nq.pop_front(), snap(), q.pop_front());
    end
  end

  initial begin
    #1 chk("reset", snap(), e(0, 0, 0, 0, 0, 0, 0));
    @(negedge mclk);
    @(negedge mclk);
    rst = 1'b0;
    key(4'd1, "a1", e(1, 10, 0, 0, 0, 0, 0));
    key(4'd2, "a2", e(2, 12, 0, 0, 0, 0, 0));
    key(4'd3, "a3", e(3, 12, 30, 0, 0, 0, 0));
    key(4'd4, "a4", e(4, 12, 34, 0, 0, 0, 0));
    key(4'd0, "a5", e(5, 12, 34, 0, 0, 0, 0));
    key(4'd7, "a6", e(6, 12, 34, 7, 0, 0, 0));
    key(4'd3, "a7", e(7, 12, 34, 7, 30, 0, 0));
    key(4'd0, "a8", e(8, 12, 34, 7, 30, 0, 0));
    st(1'b0, 4'd0, 1'b1, "a_tick", e(8, 12, 35, 7, 30, 0, 0));
    key(CL, "a_clr", e(0, 0, 0, 0, 0, 0, 0));
    key(4'd3, "b_htens_rej", e(0, 0, 0, 0, 0, 0, 1));
    key(4'd2, "b2", e(1, 20, 0, 0, 0, 0, 0));
    key(4'd5, "b_hones_rej", e(1, 20, 0, 0, 0, 0, 1));
    idle("b_err_drop", e(1, 20, 0, 0, 0, 0, 0));
    key(4'd3, "b3", e(2, 23, 0, 0, 0, 0, 0));
    key(4'd6, "b_mtens_rej", e(2, 23, 0, 0, 0, 0, 1));
    key(4'd12, "b_code12", e(2, 23, 0, 0, 0, 0, 0));
    key(4'd5, "b5", e(3, 23, 50, 0, 0, 0, 0));
    key(4'd9, "b9", e(4, 23, 59, 0, 0, 0, 0));
    st(1'b0, 4'd0, 1'b1, "b_tick_entry", e(4, 23, 59, 0, 0, 0, 0));
    for (int i = 5; i <= 8; i++) key(4'd0, "b_tz", e(i, 23, 59, 0, 0, 0, 0));
    st(1'b0, 4'd0, 1'b1, "b_wrap", e(8, 0, 0, 0, 0, 0, 0));
    idle("b_alarm", e(8, 0, 0, 0, 0, 1, 0));
    idle("b_alarm_end", e(8, 0, 0, 0, 0, 0, 0));
    st(1'b1, 4'd5, 1'b1, "b_dig_tick", e(8, 0, 1, 0, 0, 0, 0));
    st(1'b1, 4'd13, 1'b1, "b_ign_tick", e(8, 0, 2, 0, 0, 0, 0));
    idle("b_no_alarm", e(8, 0, 2, 0, 0, 0, 0));
    key(CL, "b_clr", e(0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++) key(4'd0, "z_entry", e(i, 0, 0, 0, 0, 0, 0));
    idle("z_no_alarm", e(8, 0, 0, 0, 0, 0, 0));
    idle("z_no_alarm2", e(8, 0, 0, 0, 0, 0, 0));
    key(CL, "z_clr", e(0, 0, 0, 0, 0, 0, 0));
    key(4'd0, "c1", e(1, 0, 0, 0, 0, 0, 0));
    key(4'd6, "c2", e(2, 6, 0, 0, 0, 0, 0));
    key(4'd5, "c3", e(3, 6, 50, 0, 0, 0, 0));
    key(4'd9, "c4", e(4, 6, 59, 0, 0, 0, 0));
    key(4'd0, "c5", e(5, 6, 59, 0, 0, 0, 0));
    key(4'd7, "c6", e(6, 6, 59, 7, 0, 0, 0));
    key(4'd0, "c7", e(7, 6, 59, 7, 0, 0, 0));
    key(4'd0, "c8", e(8, 6, 59, 7, 0, 0, 0));
    st(1'b0, 4'd0, 1'b1, "c_tick", e(8, 7, 0, 7, 0, 0, 0));
    idle("c_alarm", e(8, 7, 0, 7, 0, 1, 0));
    idle("c_alarm_end", e(8, 7, 0, 7, 0, 0, 0));
    key(CL, "c_clr", e(0, 0, 0, 0, 0, 0, 0));
    key(4'd1, "d1", e(1, 10, 0, 0, 0, 0, 0));
    key(4'd2, "d2", e(2, 12, 0, 0, 0, 0, 0));
    key(4'd3, "d3", e(3, 12, 30, 0, 0, 0, 0));
    key(4'd4, "d4", e(4, 12, 34, 0, 0, 0, 0));
    key(4'd0, "d5", e(5, 12, 34, 0, 0, 0, 0));
    key(4'd7, "d6", e(6, 12, 34, 7, 0, 0, 0));
    key(4'd3, "d7", e(7, 12, 34, 7, 30, 0, 0));
    key(4'd5, "d8", e(8, 12, 34, 7, 35, 0, 0));
    st(1'b1, BK, 1'b1, "d_back_tick", e(7, 12, 34, 7, 30, 0, 0));
    key(BK, "d_back", e(6, 12, 34, 7, 0, 0, 0));
    key(4'd6, "d_mtens_rej", e(6, 12, 34, 7, 0, 0, 1));
    key(4'd4, "d_redo", e(7, 12, 34, 7, 40, 0, 0));
    key(CL, "d_clr", e(0, 0, 0, 0, 0, 0, 0));
    key(BK, "d_back0", e(0, 0, 0, 0, 0, 0, 0));
    key(4'd1, "e1", e(1, 10, 0, 0, 0, 0, 0));
    key(4'd2, "e2", e(2, 12, 0, 0, 0, 0, 0));
    key(4'd3, "e3", e(3, 12, 30, 0, 0, 0, 0));
    key(4'd4, "e4", e(4, 12, 34, 0, 0, 0, 0));
    key(4'd0, "e5", e(5, 12, 34, 0, 0, 0, 0));
    idle("e_hold", e(5, 12, 34, 0, 0, 0, 0));
    @(posedge mclk);
    #3 rst = 1'b1;
    #1 chk("async_rst", snap(), e(0, 0, 0, 0, 0, 0, 0));
    @(negedge mclk);
    rst = 1'b0;
    key(4'd2, "e_restart", e(1, 20, 0, 0, 0, 0, 0));
    idle("e_end", e(1, 20, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge mclk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
